// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
//   8N1 serial transmit engine with an input byte FIFO.
//   Bytes arrive over a ready/valid handshake, are buffered in a circular
//   FIFO, and are shifted out LSB first. A frame is one start bit (0), eight
//   data bits and one stop bit (1). Each bit lasts CLOCK_FREQ/BAUD_RATE cycles.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous reset, active low
//   data_in        byte to transmit
//   data_in_valid  data_in is valid this cycle
//   data_in_ready  FIFO can take a byte this cycle
//   serial_out     UART TX line, idle high (registered)
//   tx_busy        a byte is queued or a frame is in flight (registered)
//   fifo_count     bytes queued, not counting the frame in flight
// -----------------------------------------------------------------------------
module uart_transmitter #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  output logic                          serial_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int CYC_W = $clog2(SYMBOL_EDGE_TIME);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q,  state_d;
  logic [CYC_W-1:0]   cyc_q,    cyc_d;
  logic [2:0]         bit_q,    bit_d;
  logic [7:0]         shift_q,  shift_d;
  logic               serial_q, serial_d;
  logic               busy_q,   busy_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         mem_d [FIFO_DEPTH];

  logic push, pop, sym_end, fifo_empty;

  assign data_in_ready = (count_q != CNT_FULL);
  assign serial_out    = serial_q;
  assign tx_busy       = busy_q;
  assign fifo_count    = count_q;

  always_comb begin
    push       = data_in_valid && data_in_ready;
    pop        = 1'b0;
    sym_end    = (cyc_q == CYC_LAST);
    fifo_empty = (count_q == '0);

    state_d  = state_q;
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    serial_d = serial_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    mem_d    = mem_q;

    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        if (!fifo_empty) pop = 1'b1;
      end
      START: begin
        if (sym_end) begin
          state_d  = DATA;
          cyc_d    = '0;
          serial_d = shift_q[0];
          shift_d  = {1'b0, shift_q[7:1]};
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      DATA: begin
        if (sym_end) begin
          cyc_d = '0;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d  = STOP;
            serial_d = 1'b1;
          end else begin
            serial_d = shift_q[0];
            shift_d  = {1'b0, shift_q[7:1]};
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      STOP: begin
        if (sym_end) begin
          cyc_d = '0;
          // Chain straight into the next start bit when more bytes wait.
          if (!fifo_empty) pop = 1'b1;
          else begin
            state_d  = IDLE;
            serial_d = 1'b1;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
      end
    endcase

    // The popped byte is latched whole; its bit 0 goes out after the start bit.
    if (pop) begin
      state_d  = START;
      serial_d = 1'b0;
      cyc_d    = '0;
      bit_d    = '0;
      shift_d  = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (push) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Computed from next-state values so the flop mirrors the visible state.
    busy_d = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cyc_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
//   Directed bench for uart_transmitter at 10 cycles/bit, 4-entry FIFO.
// -----------------------------------------------------------------------------
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic       serial_out;
  logic       tx_busy;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  uart_transmitter #(
    .CLOCK_FREQ(1000),
    .BAUD_RATE (100),
    .FIFO_DEPTH(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .serial_out   (serial_out),
    .tx_busy      (tx_busy),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called just after the edge that starts the start bit; consumes 100 cycles.
  task automatic check_frame(input logic [7:0] b, input string nm);
    logic exp;
    int   bad;
    for (int s = 0; s < 10; s++) begin
      exp = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : b[s-1];
      bad = 0;
      for (int c = 0; c < 10; c++) begin
        if (serial_out !== exp) bad++;
        tick();
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s sym%0d: %0d of 10 cycles not at required level %b", nm, s, bad, exp);
      end
    end
  endtask

  task automatic check_idle(input string nm);
    checks++;
    if (serial_out !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 3'd0 || data_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: serial=%b busy=%b count=%0d ready=%b, required 1 0 0 1",
               nm, serial_out, tx_busy, fifo_count, data_in_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; data_in_valid = 1'b1; data_in = 8'h5A;
    repeat (3) tick();
    check_idle("reset_held");
    rst = 1'b1; data_in_valid = 1'b0;
    tick();
    check_idle("reset_no_push");
  endtask

  task automatic test_single;
    data_in = 8'hA5; data_in_valid = 1'b1;
    tick();                      // edge N: push
    data_in_valid = 1'b0;
    checks++;
    if (serial_out !== 1'b1 || fifo_count !== 3'd1 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_push: serial=%b count=%0d busy=%b, required 1 1 1",
               serial_out, fifo_count, tx_busy);
    end
    tick();                      // edge N+1: start bit
    check_frame(8'hA5, "single_A5");
    check_idle("single_done");   // edge N+101
  endtask

  task automatic test_fill;
    data_in = 8'h01; data_in_valid = 1'b1;
    fork
      begin
        tick(); tick();
        for (int i = 1; i <= 5; i++) check_frame(8'(i), $sformatf("fill_%0d", i));
      end
      begin
        for (int i = 2; i <= 5; i++) begin
          tick();
          data_in = 8'(i);
        end
        tick();                  // edge N+4: 0x05 accepted
        checks++;
        if (fifo_count !== 3'd4 || data_in_ready !== 1'b0) begin
          errors++;
          $display("FAIL fill_full: count=%0d ready=%b, required 4 0", fifo_count, data_in_ready);
        end
        data_in = 8'h06;
        tick();                  // dropped
        data_in_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd4) begin
          errors++;
          $display("FAIL fill_drop: count=%0d, required 4", fifo_count);
        end
      end
    join
    check_idle("fill_done");
    begin
      int lows = 0;
      for (int c = 0; c < 20; c++) begin
        if (serial_out !== 1'b1) lows++;
        tick();
      end
      checks++;
      if (lows != 0) begin
        errors++;
        $display("FAIL fill_no_sixth: %0d low cycles after drain, required 0", lows);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] seq [8];
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
    seq[4] = 8'h55; seq[5] = 8'h66; seq[6] = 8'h77; seq[7] = 8'h88;
    data_in = seq[0]; data_in_valid = 1'b1;
    fork
      begin
        tick(); tick();
        for (int i = 0; i < 8; i++) check_frame(seq[i], $sformatf("b2b_%0d", i));
      end
      begin
        for (int i = 1; i <= 4; i++) begin
          tick();
          data_in = seq[i];
        end
        tick();                  // edge N+4, count 4
        for (int k = 5; k < 8; k++) begin
          int w;
          int req_w;
          req_w = (k == 5) ? 97 : 99;
          data_in = seq[k];
          w = 0;
          while (!data_in_ready && w < 150) begin
            tick();
            w++;
          end
          checks++;
          if (w != req_w || fifo_count !== 3'd3) begin
            errors++;
            $display("FAIL b2b_pop_%0d: waited %0d count=%0d, required %0d 3", k, w, fifo_count, req_w);
          end
          tick();                // push accepted
          checks++;
          if (fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL b2b_push_%0d: count=%0d, required 4", k, fifo_count);
          end
        end
        data_in_valid = 1'b0;
      end
    join
    check_idle("b2b_done");
  endtask

  task automatic test_reset_mid;
    data_in = 8'hFF; data_in_valid = 1'b1;
    tick();                      // N
    data_in = 8'hAA;
    tick();                      // N+1 (0xFF popped)
    data_in = 8'hBB;
    tick();                      // N+2
    data_in_valid = 1'b0;
    repeat (42) tick();          // N+44, inside data bit 3
    checks++;
    if (serial_out !== 1'b1 || fifo_count !== 3'd2 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: serial=%b count=%0d busy=%b, required 1 2 1",
               serial_out, fifo_count, tx_busy);
    end
    rst = 1'b0;
    tick();
    check_idle("midrst_post");
    rst = 1'b1;
    begin
      int bad = 0;
      for (int c = 0; c < 150; c++) begin
        tick();
        if (serial_out !== 1'b1 || tx_busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL midrst_quiet: %0d active cycles after reset, required 0", bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
